// File: rtl/io_timer.sv
// Memory-mapped countdown timer on the p18240 bus: PERIOD/COUNT/CTRL-STATUS registers, prescaled ticks, irq.
// Latency: reads are combinational (zero cycles); writes and timer state update on the next rising clock edge.
// Backpressure: none; every bus access completes in the cycle it is presented, the bus never stalls.
module io_timer #(
  parameter logic [15:0] BASE_ADDR = 16'h2002,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic [15:0] memAddr,
  input  logic        re_L,
  input  logic        we_L,
  input  logic [15:0] dataIn,
  output logic [15:0] dataOut,
  output logic        drive_L,
  output logic        irq
);

  typedef enum logic {IDLE, RUN} timerState_t;

  localparam logic [15:0] COUNT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] CTRL_ADDR  = BASE_ADDR + 16'd2;
  localparam logic [15:0] PRESC_MAX  = 16'(PRESCALE - 1);

  timerState_t state, stateNext;
  logic [15:0] period, periodNext;
  logic [15:0] count, countNext;
  logic [15:0] prescaler, prescNext;
  logic        enable, enableNext;
  logic        reload, reloadNext;
  logic        ie, ieNext;
  logic        done, doneNext;

  logic        selPeriod, selCount, selCtrl;
  logic        wrPeriod, wrCtrl, rdStatus;
  logic        tick, expire, zeroStart;
  logic [15:0] statusWord;

  assign selPeriod = (memAddr == BASE_ADDR);
  assign selCount  = (memAddr == COUNT_ADDR);
  assign selCtrl   = (memAddr == CTRL_ADDR);

  assign wrPeriod = ~we_L & selPeriod;
  assign wrCtrl   = ~we_L & selCtrl;
  assign rdStatus = ~re_L & selCtrl;

  assign statusWord = {done, 11'b0, (state == RUN), ie, reload, enable};

  // Read path: the MDR latches dataOut at the same edge, so it must be the pre-edge value.
  assign drive_L = ~(~re_L & (selPeriod | selCount | selCtrl));

  always_comb begin
    dataOut = 16'h0000;
    if (!re_L) begin
      if (selPeriod)     dataOut = period;
      else if (selCount) dataOut = count;
      else if (selCtrl)  dataOut = statusWord;
    end
  end

  assign irq = done & ie;

  assign tick      = (state == RUN) && (prescaler == PRESC_MAX);
  assign expire    = tick && (count == 16'd1);
  assign zeroStart = wrCtrl && dataIn[0] && (period == 16'h0000);

  always_comb begin
    stateNext  = state;
    periodNext = period;
    countNext  = count;
    prescNext  = prescaler;
    enableNext = enable;
    reloadNext = reload;
    ieNext     = ie;
    doneNext   = done;

    if (state == RUN) begin
      prescNext = tick ? 16'h0000 : prescaler + 16'd1;
      if (tick) begin
        if (count == 16'd1) begin
          // Reload samples the pre-edge period; a PERIOD write on this edge lands next time.
          if (reload && (period != 16'h0000)) begin
            countNext = period;
          end else begin
            countNext  = 16'h0000;
            enableNext = 1'b0;
            stateNext  = IDLE;
          end
        end else begin
          countNext = count - 16'd1;
        end
      end
    end

    // A software CTRL write overrides whatever the timer itself would have done this edge.
    if (wrCtrl) begin
      enableNext = dataIn[0];
      reloadNext = dataIn[1];
      ieNext     = dataIn[2];
      if (dataIn[0] && (period != 16'h0000)) begin
        countNext = period;
        prescNext = 16'h0000;
        stateNext = RUN;
      end else begin
        countNext = count;
        prescNext = prescaler;
        stateNext = IDLE;
        if (dataIn[0]) enableNext = 1'b0;
      end
    end

    if (wrPeriod) periodNext = dataIn;

    // Set beats clear: an expiry coinciding with a STATUS read leaves done high.
    if (rdStatus)           doneNext = 1'b0;
    if (expire || zeroStart) doneNext = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      period    <= 16'h0000;
      count     <= 16'h0000;
      prescaler <= 16'h0000;
      enable    <= 1'b0;
      reload    <= 1'b0;
      ie        <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      period    <= periodNext;
      count     <= countNext;
      prescaler <= prescNext;
      enable    <= enableNext;
      reload    <= reloadNext;
      ie        <= ieNext;
      done      <= doneNext;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Bench for io_timer: elapsed-time behavioural model checked every cycle, plus directed literal reads.
module tb_io_timer;

  localparam int P = 4;

  logic        clock = 1'b0;
  logic        reset_L = 1'b1;
  logic [15:0] memAddr = 16'h0000;
  logic        re_L = 1'b1;
  logic        we_L = 1'b1;
  logic [15:0] dataIn = 16'h0000;
  logic [15:0] dataOut;
  logic        drive_L;
  logic        irq;

  int nChecks = 0;
  int nFail = 0;

  io_timer #(.BASE_ADDR(16'h2002), .PRESCALE(P)) dut (
    .clock(clock), .reset_L(reset_L), .memAddr(memAddr), .re_L(re_L), .we_L(we_L),
    .dataIn(dataIn), .dataOut(dataOut), .drive_L(drive_L), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is described by the value loaded and the clock cycles spent running since the load.
  logic [15:0] mPeriod = 16'h0000;
  logic        mEnable = 1'b0, mReload = 1'b0, mIe = 1'b0, mDone = 1'b0, mRun = 1'b0;
  int          mLoad = 0, mElapsed = 0;
  logic        mWrP, mWrC, mRdS, mExpire, mDoneN;

  function automatic logic [15:0] mCount();
    return 16'(mLoad - mElapsed / P);
  endfunction

  always @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      mPeriod = 16'h0000; mEnable = 1'b0; mReload = 1'b0; mIe = 1'b0;
      mDone = 1'b0; mRun = 1'b0; mLoad = 0; mElapsed = 0;
    end else begin
      mWrP = !we_L && memAddr == 16'h2002;
      mWrC = !we_L && memAddr == 16'h2004;
      mRdS = !re_L && memAddr == 16'h2004;
      mExpire = mRun && (mElapsed + 1 == mLoad * P);
      mDoneN = mDone;
      if (mRdS) mDoneN = 1'b0;
      if (mExpire) mDoneN = 1'b1;
      if (mWrC) begin
        mEnable = dataIn[0]; mReload = dataIn[1]; mIe = dataIn[2];
        if (dataIn[0] && mPeriod != 16'h0000) begin
          mLoad = int'(mPeriod); mElapsed = 0; mRun = 1'b1;
        end else begin
          mRun = 1'b0;
          if (dataIn[0]) begin mDoneN = 1'b1; mEnable = 1'b0; end
        end
      end else if (mExpire) begin
        if (mReload && mPeriod != 16'h0000) begin
          mLoad = int'(mPeriod); mElapsed = 0;
        end else begin
          mLoad = 0; mElapsed = 0; mRun = 1'b0; mEnable = 1'b0;
        end
      end else if (mRun) begin
        mElapsed++;
      end
      mDone = mDoneN;
      if (mWrP) mPeriod = dataIn;
    end
  end

  always @(negedge clock) begin
    logic        hit;
    logic [15:0] expData;
    hit = !re_L && (memAddr == 16'h2002 || memAddr == 16'h2003 || memAddr == 16'h2004);
    expData = 16'h0000;
    if (hit) begin
      if (memAddr == 16'h2002)      expData = mPeriod;
      else if (memAddr == 16'h2003) expData = mCount();
      else expData = {mDone, 11'b0, mRun, mIe, mReload, mEnable};
    end
    check("cmpDrive", {15'b0, drive_L}, {15'b0, !hit});
    check("cmpData", dataOut, expData);
    check("cmpIrq", {15'b0, irq}, {15'b0, mDone & mIe});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    memAddr = a; dataIn = d; we_L = 1'b0;
    @(posedge clock); #1;
    we_L = 1'b1; memAddr = 16'h0000; dataIn = 16'h0000;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp, input logic expDrive);
    memAddr = a; re_L = 1'b0;
    @(negedge clock);
    check(name, dataOut, exp);
    check({name, "_drv"}, {15'b0, drive_L}, {15'b0, expDrive});
    @(posedge clock); #1;
    re_L = 1'b1; memAddr = 16'h0000;
  endtask

  initial begin
    #1 reset_L = 1'b0;
    idle(2);
    check("rstIrq", {15'b0, irq}, 16'h0000);
    check("rstDrive", {15'b0, drive_L}, 16'h0001);
    check("rstData", dataOut, 16'h0000);
    reset_L = 1'b1;
    idle(1);

    rd("rdPeriod0", 16'h2002, 16'h0000, 1'b0);
    rd("rdCount0", 16'h2003, 16'h0000, 1'b0);
    rd("rdStatus0", 16'h2004, 16'h0000, 1'b0);
    rd("rd2000", 16'h2000, 16'h0000, 1'b1);
    rd("rd2005", 16'h2005, 16'h0000, 1'b1);

    // One-shot, period 3: ticks 4, 8, 12 cycles after the start edge.
    wr(16'h2002, 16'h0003);
    rd("rdPeriod3", 16'h2002, 16'h0003, 1'b0);
    wr(16'h2004, 16'h0001);
    idle(3);
    rd("osCnt3", 16'h2003, 16'h0003, 1'b0);
    idle(3);
    rd("osCnt2", 16'h2003, 16'h0002, 1'b0);
    idle(2);
    rd("osCnt1", 16'h2003, 16'h0001, 1'b0);
    rd("osStatPre", 16'h2004, 16'h0009, 1'b0);
    rd("osStatDone", 16'h2004, 16'h8000, 1'b0);
    rd("osStatClr", 16'h2004, 16'h0000, 1'b0);
    rd("osCntEnd", 16'h2003, 16'h0000, 1'b0);

    // Auto-reload with irq, period 2: expiries every 8 cycles.
    wr(16'h2002, 16'h0002);
    wr(16'h2004, 16'h0007);
    idle(8);
    check("rlIrqUp", {15'b0, irq}, 16'h0001);
    rd("rlStat", 16'h2004, 16'h800F, 1'b0);
    check("rlIrqClr", {15'b0, irq}, 16'h0000);
    rd("rlCnt", 16'h2003, 16'h0002, 1'b0);
    idle(5);
    rd("rlStatColl", 16'h2004, 16'h000F, 1'b0);
    check("rlIrqColl", {15'b0, irq}, 16'h0001);
    idle(7);
    wr(16'h2002, 16'h0005);
    rd("rlOldPer", 16'h2003, 16'h0002, 1'b0);
    idle(6);
    rd("rlCnt1", 16'h2003, 16'h0001, 1'b0);
    rd("rlNewPer", 16'h2003, 16'h0005, 1'b0);
    wr(16'h2004, 16'h0000);
    rd("rlStopStat", 16'h2004, 16'h8000, 1'b0);

    // Zero period start: done immediately, enable cleared.
    wr(16'h2002, 16'h0000);
    wr(16'h2004, 16'h0001);
    rd("zpStat", 16'h2004, 16'h8000, 1'b0);
    rd("zpStatClr", 16'h2004, 16'h0000, 1'b0);

    // Stop after 9 cycles of a period-16 run: two ticks taken.
    wr(16'h2002, 16'h0010);
    wr(16'h2004, 16'h0001);
    idle(8);
    wr(16'h2004, 16'h0000);
    rd("stCnt", 16'h2003, 16'h000E, 1'b0);
    rd("stStat", 16'h2004, 16'h0000, 1'b0);
    idle(3);
    rd("stCntHeld", 16'h2003, 16'h000E, 1'b0);

    // Reset in the middle of a run with irq pending: irq drops without a clock edge.
    wr(16'h2002, 16'h0001);
    wr(16'h2004, 16'h0005);
    idle(5);
    check("mrIrqUp", {15'b0, irq}, 16'h0001);
    wr(16'h2002, 16'h0010);
    wr(16'h2004, 16'h0005);
    idle(3);
    #2 reset_L = 1'b0;
    #1 check("mrIrqAsync", {15'b0, irq}, 16'h0000);
    rd("mrPeriod", 16'h2002, 16'h0000, 1'b0);
    rd("mrCount", 16'h2003, 16'h0000, 1'b0);
    rd("mrStatus", 16'h2004, 16'h0000, 1'b0);
    reset_L = 1'b1;
    idle(2);
    rd("mrCountAfter", 16'h2003, 16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
